uart_tx: RTL and testbench
==========================

# uart_tx

Asynchronous serial (UART) transmitter: on a start request it latches one byte and drives a standard 8N1 frame (start bit, 8 data bits LSB first, one stop bit) on a single idle-high line at a fixed baud rate derived from the system clock. It is the transmit half of the stage-1 UART and is driven by a byte producer through a single-signal start request.

## Interface
- CLK_FREQ, 50_000_000: system clock frequency in Hz.
- BAUD, 9600: line rate in bit/s.
- CLKS_PER_BIT, CLK_FREQ/BAUD (integer division, 5208 at the defaults): clock cycles per bit. Derived locally, not overridden by instantiators.
- clk, input, 1: system clock. The block uses one clock.
- rst, input, 1: synchronous, active-low reset. It acts on the rising edge of clk.
- tx_data, input, 8: byte to send. It is sampled only at the edge where a start is accepted.
- tx_ready, input, 1: start request. It is level-sensitive and sampled every cycle.
- tx, output, 1: serial line. It idles high.
- tx_busy, output, 1: high from frame acceptance until the stop bit completes.

## Operation
- States: IDLE, START, DATA, STOP.
- IDLE:
  - tx=1 and tx_busy=0.
  - If tx_ready=1 at a rising edge, latch tx_data into a shift register, clear the bit counter and clear the baud counter, then go to START.
- START:
  - tx=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - tx equals the current shift-register LSB.
  - After each CLKS_PER_BIT cycles, shift right and increment the bit index 0..7.
  - After bit 7 completes, go to STOP.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- tx_ready is ignored in START, DATA and STOP. It has no effect mid-frame, and tx_data changes mid-frame do not alter the frame in flight.
- If tx_ready is still high when the block returns to IDLE, a new frame starts one cycle later with the then-current tx_data. Back-to-back frames are therefore legal.
- tx is a registered output and must be glitch-free.
- tx_busy = (state != IDLE).
- Reset (rst=0 at a rising edge), in any state including mid-frame:
  - state=IDLE, tx=1, tx_busy=0;
  - baud counter, bit index and shift register cleared.
  - The partial frame is abandoned; no completion is emitted.
- The baud counter runs 0..CLKS_PER_BIT-1 and wraps. Its width is $clog2(CLKS_PER_BIT).

## Timing
- Latency: with tx_ready sampled high in IDLE at edge N, tx falls at edge N+1.
- Each bit lasts exactly CLKS_PER_BIT cycles:
  - start bit: edges N+1 .. N+CLKS_PER_BIT;
  - data bit k begins at edge N+1+(k+1)*CLKS_PER_BIT;
  - stop bit begins at edge N+1+9*CLKS_PER_BIT.
- Frame length is 10*CLKS_PER_BIT cycles: 52080 cycles, about 1.0416 ms at the defaults.
- tx_busy rises at N+1 and falls at N+1+10*CLKS_PER_BIT.
- A 2-cycle tx_ready pulse produces exactly one frame.
- Reset values: tx=1, tx_busy=0.

## Structure
- Shared package uart_pkg holds:
  - the state enum (IDLE, START, DATA, STOP);
  - a function computing CLKS_PER_BIT from CLK_FREQ and BAUD.
  The future rx block reuses both.
- One sub-module is natural: uart_baud_tick. It is a counter with a synchronous clear that emits a one-cycle tick every CLKS_PER_BIT cycles and is cleared on frame acceptance.
- The FSM, shift register and bit index live in the top module.

## Test plan
- Reset:
  - Hold rst=0 for 5 cycles, release and wait 300 µs -> tx=1 and tx_busy=0 throughout.
  - A reset pulse after release again yields tx=1.
- Single byte:
  - tx_data=0xA5 with a 2-cycle tx_ready pulse -> tx sequence 0,1,0,1,0,0,1,0,1,1.
  - Each bit is 5208 cycles; tx falls 1 cycle after acceptance.
  - tx_busy is high for 52080 cycles.
- Second byte after idle:
  - tx_data=0x5A, 1.5 ms later -> tx sequence 0,0,1,0,1,1,0,1,0,1.
  - Exactly one frame is sent per pulse.
- Mid-frame disturbance:
  - Change tx_data and pulse tx_ready during data bit 3 of 0xA5 -> the frame is unchanged and no second frame follows.
- Held request:
  - Keep tx_ready=1 continuously with tx_data=0x00 -> back-to-back frames.
  - The next start bit begins 1 cycle after the previous stop bit ends.
- Reset mid-frame:
  - Assert rst=0 during data bit 4 -> tx=1 and tx_busy=0 at the next edge.
  - After release, a new 0x3C request transmits a clean full frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding and baud-rate helpers.
// The receive block reuses the state enum and the divisor functions.
package uart_pkg;

  // Frame phases of an 8N1 character.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int DATA_BITS = 8;

  // Clock cycles per bit; integer division truncates toward zero.
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  // Width for a counter running 0..n-1, kept at least one bit wide.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte producer to transmitter connection: start request, byte, line and busy.
interface uart_tx_if;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       tx;
  logic       tx_busy;

  // Producer side: requests frames and observes the line.
  modport master (
    output tx_data,
    output tx_ready,
    input  tx,
    input  tx_busy
  );

  // Transmitter side.
  modport slave (
    input  tx_data,
    input  tx_ready,
    output tx,
    output tx_busy
  );
endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while running and pulses tick_o
// on the last count. A synchronous clear restarts the period at frame accept.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic run_i,
  output logic tick_o
);

  localparam int CW = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          tick;

  // Next count: clear wins, otherwise advance and wrap at the last count.
  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (clear_i) begin
      cnt_d = '0;
    end else if (run_i) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
        tick  = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = tick;

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter. A start request in IDLE latches the byte and restarts
// the bit timer; tx and tx_busy are registered from the current state, so the
// line moves one cycle after each state change and never glitches.
module uart_tx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600
) (
  input  logic      clk,
  input  logic      rst,
  uart_tx_if.slave  bus
);
  import uart_pkg::*;

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  uart_state_e state_q;
  uart_state_e state_d;
  logic [7:0]  shift_q;
  logic [7:0]  shift_d;
  logic [2:0]  bit_idx_q;
  logic [2:0]  bit_idx_d;
  logic        tx_q;
  logic        tx_d;
  logic        busy_q;
  logic        busy_d;
  logic        accept;
  logic        bit_tick;

  uart_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_tick (
    .clk     (clk),
    .rst     (rst),
    .clear_i (accept),
    .run_i   (state_q != IDLE),
    .tick_o  (bit_tick)
  );

  // Next-state, shift register and line value; requests are only seen in IDLE.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    accept    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.tx_ready) begin
          accept    = 1'b1;
          shift_d   = bus.tx_data;
          bit_idx_d = '0;
          state_d   = START;
        end
      end
      START: begin
        if (bit_tick) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_tick) begin
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == LAST_BIT) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (bit_tick) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    unique case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_q[0];
      default: tx_d = 1'b1;
    endcase

    busy_d = (state_q != IDLE);
  end

  // State and datapath registers; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.tx      = tx_q;
  assign bus.tx_busy = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx at a reduced bit period of 16 cycles.
module tb_uart_tx;

  localparam int CLK_FREQ = 160_000;
  localparam int BAUD     = 10_000;
  localparam int CPB      = 16;
  localparam int FRAME    = 10 * CPB;
  localparam int BTB      = FRAME + 1;

  typedef struct {
    logic [7:0] data;
    bit         abort_ok;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   mon_busy = 0;
  exp_t sb[$];
  int   start_cyc[$];

  uart_tx_if bus ();

  uart_tx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: decodes each frame cycle by cycle against the queued byte.
  initial begin : monitor
    exp_t        e;
    logic [9:0]  fr;
    bit          aborted;
    int          bad;
    int          busy_bad;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && bus.tx === 1'b0) begin
        mon_busy = 1;
        start_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          check("unexpected_frame", 1, 0);
          repeat (FRAME) @(negedge clk);
          mon_busy = 0;
          continue;
        end
        e        = sb.pop_front();
        fr       = {1'b1, e.data, 1'b0};
        aborted  = 0;
        busy_bad = 0;
        for (int b = 0; b < 10 && !aborted; b++) begin
          bad = 0;
          for (int c = 0; c < CPB; c++) begin
            if (b != 0 || c != 0) @(negedge clk);
            if (rst !== 1'b1) begin
              aborted = 1;
              break;
            end
            if (bus.tx !== fr[b]) bad++;
            if (bus.tx_busy !== 1'b1) busy_bad++;
          end
          if (!aborted) begin
            check($sformatf("byte_%02h_bit%0d_badcycles", e.data, b), bad, 0);
          end
        end
        if (aborted) begin
          check($sformatf("byte_%02h_unexpected_abort", e.data), e.abort_ok, 1);
        end else begin
          check($sformatf("byte_%02h_abort_expected", e.data), e.abort_ok, 0);
          check($sformatf("byte_%02h_busy_low_cycles", e.data), busy_bad, 0);
          @(negedge clk);
          check($sformatf("byte_%02h_end_tx_busy", e.data), {bus.tx, bus.tx_busy}, 2'b10);
        end
        mon_busy = 0;
      end
    end
  end

  // Two-cycle request from idle; also checks the one-cycle start latency.
  task automatic send(input logic [7:0] d, input bit abort_ok);
    exp_t e;
    e.data     = d;
    e.abort_ok = abort_ok;
    sb.push_back(e);
    bus.tx_data  = d;
    bus.tx_ready = 1'b1;
    @(negedge clk);
    check($sformatf("lat_%02h_after_accept", d), {bus.tx, bus.tx_busy}, 2'b10);
    @(negedge clk);
    check($sformatf("lat_%02h_next_edge", d), {bus.tx, bus.tx_busy}, 2'b01);
    bus.tx_ready = 1'b0;
  endtask

  task automatic wait_done(input string name, input int bound);
    int n;
    n = 0;
    while (!(sb.size() == 0 && !mon_busy && bus.tx_busy === 1'b0) && n < bound) begin
      @(negedge clk);
      n++;
    end
    check({name, "_timeout"}, (n >= bound), 0);
  endtask

  initial begin : stimulus
    int bad;
    rst          = 1'b0;
    bus.tx_ready = 1'b0;
    bus.tx_data  = 8'h00;

    // Reset held for 5 cycles, then a long idle stretch.
    repeat (5) @(negedge clk);
    check("reset_tx_busy", {bus.tx, bus.tx_busy}, 2'b10);
    rst = 1'b1;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (bus.tx !== 1'b1 || bus.tx_busy !== 1'b0) bad++;
    end
    check("idle_after_reset_badcycles", bad, 0);
    rst = 1'b0;
    @(negedge clk);
    check("reset_pulse_tx_busy", {bus.tx, bus.tx_busy}, 2'b10);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Single byte 0xA5: line 0,1,0,1,0,0,1,0,1,1.
    send(8'hA5, 0);
    wait_done("a5", FRAME + 20);

    // Second byte after a long idle: line 0,0,1,0,1,1,0,1,0,1.
    repeat (200) @(negedge clk);
    send(8'h5A, 0);
    wait_done("5a", FRAME + 20);
    repeat (10) @(negedge clk);

    // Request and new data during data bit 3 must not disturb the frame.
    send(8'hA5, 0);
    repeat (4 * CPB + CPB / 2) @(negedge clk);
    bus.tx_data  = 8'hFF;
    bus.tx_ready = 1'b1;
    repeat (2) @(negedge clk);
    bus.tx_ready = 1'b0;
    wait_done("disturb", FRAME + 20);
    repeat (3 * CPB) @(negedge clk);
    check("disturb_frames", start_cyc.size(), 3);

    // Held request: three back-to-back 0x00 frames, one idle cycle apart.
    begin
      exp_t e;
      e.data     = 8'h00;
      e.abort_ok = 0;
      repeat (3) sb.push_back(e);
    end
    bus.tx_data  = 8'h00;
    bus.tx_ready = 1'b1;
    repeat (2 * BTB + 5) @(negedge clk);
    bus.tx_ready = 1'b0;
    wait_done("held", 2 * FRAME + 20);
    if (start_cyc.size() >= 6) begin
      check("held_gap_1", start_cyc[4] - start_cyc[3], BTB);
      check("held_gap_2", start_cyc[5] - start_cyc[4], BTB);
    end else begin
      check("held_frames", start_cyc.size(), 6);
    end
    repeat (10) @(negedge clk);

    // Reset during data bit 4 abandons the frame; a fresh frame follows cleanly.
    send(8'h3C, 1);
    repeat (5 * CPB + CPB / 2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_midframe_tx_busy", {bus.tx, bus.tx_busy}, 2'b10);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_idle", {bus.tx, bus.tx_busy}, 2'b10);
    send(8'h3C, 0);
    wait_done("3c", FRAME + 20);

    repeat (3 * CPB) @(negedge clk);
    check("final_queue_empty", sb.size(), 0);
    check("total_frames", start_cyc.size(), 8);
    check("final_idle", {bus.tx, bus.tx_busy}, 2'b10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
